// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, defaults and parity helper for the UART transmitter
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS_DEFAULT    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between host logic and the UART transmitter
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
);

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period timer; bit_done pulses on the last cycle of each bit
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter; UART_TX_PARITY_EN adds a parity bit and parity_odd input
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_odd,
`endif
    output logic       tx,
    output logic       busy
);

    localparam int             BCW       = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 accept;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bus.ready = (state_q == IDLE) && !rst;
    assign accept    = bus.valid && bus.ready;
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .enable   (state_q != IDLE),
        .bit_done (bit_done)
    );

    // tx_d always carries the level of the state being entered, so the line is registered
    // and the start bit appears the cycle after accept.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shift_d = bus.data;
                    state_d = START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = calc_parity(8'(bus.data), parity_odd);
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                // bit_cnt is reused to count stop-bit periods.
                if (bit_done) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx1, busy1, tx2, busy2;
`ifdef UART_TX_PARITY_EN
    logic par_odd = 1'b0;
`endif

    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if1),
`ifdef UART_TX_PARITY_EN
        .parity_odd (par_odd),
`endif
        .tx         (tx1),
        .busy       (busy1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (par_odd),
`endif
        .tx         (tx2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] fr;
        logic       par;
    } vec_t;

    vec_t tbl [6];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    logic exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic add_frame(input logic [9:0] fr, input logic par, input int nstop);
        for (int b = 0; b < 9; b++)
            for (int c = 0; c < CPB; c++) exp_q.push_back(fr[b]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) exp_q.push_back(par);
`else
        if (par === 1'bx) $display("bad parity entry");
`endif
        for (int c = 0; c < nstop * CPB; c++) exp_q.push_back(fr[9]);
    endtask

    task automatic set_in(input int sel, input logic [7:0] d, input logic v);
        if (sel == 1) begin
            if1.data = d; if1.valid = v;
        end else begin
            if2.data = d; if2.valid = v;
        end
    endtask

    function automatic logic [2:0] rbt(input int sel);
        return (sel == 1) ? {if1.ready, busy1, tx1} : {if2.ready, busy2, tx2};
    endfunction

    task automatic send_check(input int sel, input logic [7:0] d, input logic [9:0] fr,
                              input logic par, input int nstop, input string nm, input bit noise);
        int bad_tx = 0;
        int bad_hs = 0;
        int n;
        logic [2:0] s;
        exp_q.delete();
        add_frame(fr, par, nstop);
        n = exp_q.size();
        set_in(sel, d, 1'b1);
        s = rbt(sel);
        chk({nm, "_ready_pre"}, 32'(s[2]), 32'd1);
        @(posedge clk); #1;
        set_in(sel, d, 1'b0);
        for (int k = 0; k < n; k++) begin
            s = rbt(sel);
            if (s[0] !== exp_q[k]) bad_tx++;
            if (s[2:1] !== 2'b01) bad_hs++;
            if (noise && k < n - 2) set_in(sel, 8'($urandom), 1'($urandom));
            else set_in(sel, d, 1'b0);
            @(posedge clk); #1;
        end
        chk({nm, "_tx_bad_cycles"}, 32'(bad_tx), 32'd0);
        chk({nm, "_hs_bad_cycles"}, 32'(bad_hs), 32'd0);
        chk({nm, "_idle_after"}, 32'(rbt(sel)), 32'b101);
    endtask

    initial begin
        int bad;
        logic [2:0] s;
        tbl[0] = '{8'h33, 10'b1_00110011_0, 1'b0};
        tbl[1] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        tbl[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
        tbl[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        tbl[4] = '{8'h01, 10'b1_00000001_0, 1'b1};
        tbl[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

        set_in(1, 8'h00, 1'b0);
        set_in(2, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx1), 32'd1);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_ready_masked", 32'(if1.ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_state", 32'(rbt(1)), 32'b101);

        for (int i = 0; i < 6; i++)
            send_check(1, tbl[i].d, tbl[i].fr, tbl[i].par, 1, $sformatf("vec%0d", i), 1'b0);

        send_check(1, 8'hA5, 10'b1_10100101_0, 1'b0, 1, "ignored_input", 1'b1);
        bad = 0;
        repeat (12) begin
            if (rbt(1) !== 3'b101) bad++;
            @(posedge clk); #1;
        end
        chk("no_extra_frame", 32'(bad), 32'd0);

        exp_q.delete();
        add_frame(10'b1_10111011_0, 1'b0, 1);
        exp_q.push_back(1'b1);
        add_frame(10'b1_00000000_0, 1'b0, 1);
        set_in(1, 8'hBB, 1'b1);
        @(posedge clk); #1;
        set_in(1, 8'h00, 1'b1);
        bad = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (tx1 !== exp_q[k]) bad++;
            if (k == 40) chk("b2b_ready_gap", 32'(if1.ready), 32'd1);
            @(posedge clk); #1;
            if (k == 40) set_in(1, 8'h00, 1'b0);
        end
        chk("b2b_tx_bad_cycles", 32'(bad), 32'd0);
        chk("b2b_idle_after", 32'(rbt(1)), 32'b101);

        set_in(1, 8'h00, 1'b1);
        @(posedge clk); #1;
        set_in(1, 8'h00, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("midframe_low_before_rst", 32'(tx1), 32'd0);
        rst = 1'b1;
        #1;
        chk("midframe_rst_async_tx", 32'(tx1), 32'd1);
        chk("midframe_rst_busy", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (rbt(1) !== 3'b101) bad++;
        end
        chk("midframe_no_resume", 32'(bad), 32'd0);

        send_check(2, 8'hFF, 10'b1_11111111_0, 1'b0, 2, "stop2", 1'b0);

`ifdef UART_TX_PARITY_EN
        par_odd = 1'b0;
        send_check(1, 8'h07, 10'b1_00000111_0, 1'b1, 1, "parity_even", 1'b0);
        par_odd = 1'b1;
        send_check(1, 8'h07, 10'b1_00000111_0, 1'b0, 1, "parity_odd", 1'b0);
        par_odd = 1'b0;
`endif

        s = rbt(2);
        chk("dut2_idle_end", 32'(s), 32'b101);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
